// File: rtl/pipelined_ripple_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_ripple_adder_pkg
// Brief    : Shared defaults and configuration check for the pipelined RCA.
// Revision : 1.0
// ============================================================================
package pipelined_ripple_adder_pkg;

    localparam int c_DEFAULT_WIDTH  = 16;
    localparam int c_DEFAULT_STAGES = 4;

    // Short-circuit keeps the modulo away from a zero stage count.
    function automatic bit legal_split(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipelined_ripple_adder_rca_slice.sv
`default_nettype none
// ============================================================================
// Module   : full_adder / rca_slice
// Brief    : One-bit full adder and a purely combinational SLICE-bit ripple.
// Revision : 1.0
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_slice
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int SLICE = 4
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             ci,
    output logic [SLICE-1:0] s,
    output logic             co,
    output logic             c_msb
);
    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        logic w_cin;
        logic w_cout;

        if (i == 0) begin : g_lsb
            assign w_cin = ci;
        end else begin : g_chain
            assign w_cin = g_bit[i-1].w_cout;
        end

        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_cin),
            .s  (s[i]),
            .co (w_cout)
        );
    end

    // Carry into the top bit feeds the overflow detector in the last stage.
    assign co    = g_bit[SLICE-1].w_cout;
    assign c_msb = g_bit[SLICE-1].w_cin;
endmodule
`default_nettype wire

// File: rtl/pipelined_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_ripple_adder
// Brief    : STAGES-deep pipelined ripple adder/subtractor, valid/ready on both sides.
// Revision : 1.0
// ============================================================================
module pipelined_ripple_adder
    import pipelined_ripple_adder_pkg::*;
#(
    parameter int WIDTH  = c_DEFAULT_WIDTH,
    parameter int STAGES = c_DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             co,
    output logic             ovf
);
    localparam int c_SLICE = WIDTH / STAGES;

    if (!legal_split(WIDTH, STAGES)) begin : g_bad_config
        $error("pipelined_ripple_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;

    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;
    assign w_b_eff   = sub ? ~B : B;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_LO   = k * c_SLICE;
        localparam int c_DONE = c_LO + c_SLICE;
        // Operand bits still unconsumed when the op enters this stage.
        localparam int c_LEFT = WIDTH - c_LO;

        logic [c_LEFT-1:0]  w_a_rem;
        logic [c_LEFT-1:0]  w_b_rem;
        logic               w_ci;
        logic               w_valid_in;
        logic [c_SLICE-1:0] w_s;
        logic               w_co;
        logic               w_c_msb;
        logic [c_DONE-1:0]  w_sum;
        logic               r_valid;
        logic [c_DONE-1:0]  r_sum;

        if (k == 0) begin : g_entry
            assign w_a_rem    = A;
            assign w_b_rem    = w_b_eff;
            assign w_ci       = sub | ci;
            assign w_valid_in = in_valid;
            assign w_sum      = w_s;
        end else begin : g_link
            assign w_a_rem    = g_stage[k-1].g_fwd.r_a;
            assign w_b_rem    = g_stage[k-1].g_fwd.r_b;
            assign w_ci       = g_stage[k-1].g_fwd.r_carry;
            assign w_valid_in = g_stage[k-1].r_valid;
            assign w_sum      = {w_s, g_stage[k-1].r_sum};
        end

        rca_slice #(
            .SLICE (c_SLICE)
        ) u_slice (
            .a     (w_a_rem[c_SLICE-1:0]),
            .b     (w_b_rem[c_SLICE-1:0]),
            .ci    (w_ci),
            .s     (w_s),
            .co    (w_co),
            .c_msb (w_c_msb)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                r_valid <= 1'b0;
                r_sum   <= '0;
            end else if (w_advance) begin
                r_valid <= w_valid_in;
                r_sum   <= w_sum;
            end
        end

        if (k < STAGES - 1) begin : g_fwd
            localparam int c_REST = WIDTH - c_DONE;

            logic [c_REST-1:0] r_a;
            logic [c_REST-1:0] r_b;
            logic              r_carry;
            logic              w_unused_c_msb;

            assign w_unused_c_msb = w_c_msb;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a     <= '0;
                    r_b     <= '0;
                    r_carry <= 1'b0;
                end else if (w_advance) begin
                    r_a     <= w_a_rem[c_LEFT-1:c_SLICE];
                    r_b     <= w_b_rem[c_LEFT-1:c_SLICE];
                    r_carry <= w_co;
                end
            end
        end else begin : g_tail
            logic r_co;
            logic r_ovf;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_co  <= 1'b0;
                    r_ovf <= 1'b0;
                end else if (w_advance) begin
                    r_co  <= w_co;
                    r_ovf <= w_co ^ w_c_msb;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].r_valid;
    assign S         = g_stage[STAGES-1].r_sum;
    assign co        = g_stage[STAGES-1].g_tail.r_co;
    assign ovf       = g_stage[STAGES-1].g_tail.r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_pipelined_ripple_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_ripple_adder
// Brief    : Directed and streaming checks of 16/4, 8/1 and 32/8 adder configurations.
// Revision : 1.0
// ============================================================================
module tb_pipelined_ripple_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];
    logic [2:0]  ci_v, sub_v, iv, orr;
    logic [2:0]  ir, ov, co_w, ovf_w;
    logic [15:0] s0;
    logic [7:0]  s1;
    logic [31:0] s2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .A(a_v[0][15:0]), .B(b_v[0][15:0]), .ci(ci_v[0]), .sub(sub_v[0]),
        .out_valid(ov[0]), .out_ready(orr[0]), .S(s0), .co(co_w[0]), .ovf(ovf_w[0]));

    pipelined_ripple_adder #(.WIDTH(8), .STAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .A(a_v[1][7:0]), .B(b_v[1][7:0]), .ci(ci_v[1]), .sub(sub_v[1]),
        .out_valid(ov[1]), .out_ready(orr[1]), .S(s1), .co(co_w[1]), .ovf(ovf_w[1]));

    pipelined_ripple_adder #(.WIDTH(32), .STAGES(8)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
        .A(a_v[2]), .B(b_v[2]), .ci(ci_v[2]), .sub(sub_v[2]),
        .out_valid(ov[2]), .out_ready(orr[2]), .S(s2), .co(co_w[2]), .ovf(ovf_w[2]));

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    function automatic int wid(input int d);
        case (d)
            0:       return 16;
            1:       return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int lat(input int d);
        case (d)
            0:       return 4;
            1:       return 1;
            default: return 8;
        endcase
    endfunction

    // {ovf, co, S} of the selected DUT, S zero-extended to 32 bits.
    function automatic logic [33:0] dut_res(input int d);
        case (d)
            0:       return {ovf_w[0], co_w[0], 16'd0, s0};
            1:       return {ovf_w[1], co_w[1], 24'd0, s1};
            default: return {ovf_w[2], co_w[2], s2};
        endcase
    endfunction

    // Reference: wide arithmetic for S/co, sign rule for overflow.
    function automatic logic [33:0] model(input int w, input logic [31:0] a, input logic [31:0] b,
                                          input logic ci, input logic sub);
        logic [31:0] mask, aa, bb, s;
        logic [32:0] full;
        logic        cin, c_out, v;
        mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        aa    = a & mask;
        bb    = (sub ? ~b : b) & mask;
        cin   = sub ? 1'b1 : ci;
        full  = {1'b0, aa} + {1'b0, bb} + {32'd0, cin};
        s     = full[31:0] & mask;
        c_out = full[w];
        v     = (aa[w-1] == bb[w-1]) && (s[w-1] != aa[w-1]);
        return {v, c_out, s};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // One isolated op; measures edges from accept to out_valid.
    task automatic single_op(input int d, input logic [31:0] a, input logic [31:0] b,
                             input logic ci, input logic sub, input logic [33:0] exp,
                             input string name);
        int n;
        a_v[d] = a; b_v[d] = b; ci_v[d] = ci; sub_v[d] = sub;
        iv[d] = 1'b1; orr[d] = 1'b1;
        #1;
        check({name, " in_ready"}, 64'(ir[d]), 64'd1);
        @(posedge clk); #1;
        iv[d] = 1'b0;
        n = 1;
        while (!ov[d] && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(lat(d)));
        check({name, " result"}, 64'(dut_res(d)), 64'(exp));
        @(posedge clk); #1;
        check({name, " drained"}, 64'(ov[d]), 64'd0);
    endtask

    // mode 0: continuous, 1: 3-cycle consumer stall after two results, 2: random.
    task automatic run_stream(input int d, input int nops, input int mode, input string name);
        logic [33:0] exp_mem [1024];
        logic [34:0] held_val;
        int          sent, wr, rd, cyc, first_out, last_out, stalls;
        bit          held, accepted;
        sent = 0; wr = 0; rd = 0; cyc = 0; first_out = -1; last_out = 0; stalls = 0;
        held = 1'b0;
        iv[d] = 1'b0;
        while (rd < nops && cyc < nops * 10 + 50) begin
            if (!iv[d] && sent < nops && (mode != 2 || $urandom_range(0, 3) != 0)) begin
                a_v[d]   = $urandom;
                b_v[d]   = $urandom;
                ci_v[d]  = 1'($urandom_range(0, 1));
                sub_v[d] = 1'($urandom_range(0, 1));
                iv[d]    = 1'b1;
            end
            if (mode == 2) begin
                orr[d] = ($urandom_range(0, 3) != 0);
            end else if (mode == 1 && rd >= 2 && stalls < 3) begin
                orr[d] = 1'b0;
                stalls++;
            end else begin
                orr[d] = 1'b1;
            end
            #1;
            if (held)
                check({name, " held"}, 64'({ov[d], dut_res(d)}), 64'(held_val));
            if (mode != 0)
                check({name, " in_ready"}, 64'(ir[d]), 64'(ov[d] ? orr[d] : 1'b1));
            accepted = iv[d] && ir[d];
            if (accepted) begin
                exp_mem[wr] = model(wid(d), a_v[d], b_v[d], ci_v[d], sub_v[d]);
                wr++;
                sent++;
            end
            if (ov[d] && orr[d]) begin
                if (rd < wr)
                    check($sformatf("%s res%0d", name, rd), 64'(dut_res(d)), 64'(exp_mem[rd]));
                else
                    check({name, " unexpected output"}, 64'(rd), 64'(wr));
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                rd++;
            end
            held     = ov[d] && !orr[d];
            held_val = {ov[d], dut_res(d)};
            @(posedge clk); #1;
            if (accepted) iv[d] = 1'b0;
            cyc++;
        end
        iv[d]  = 1'b0;
        orr[d] = 1'b1;
        check({name, " results"}, 64'(rd), 64'(nops));
        check({name, " accepts"}, 64'(wr), 64'(nops));
        check({name, " no extra"}, 64'(ov[d]), 64'd0);
        if (mode == 0)
            check({name, " back-to-back"}, 64'(last_out - first_out), 64'(nops - 1));
    endtask

    initial begin
        int          seen;
        logic [31:0] m;
        rst = 1'b1; iv = '0; orr = '0; ci_v = '0; sub_v = '0;
        for (int d = 0; d < 3; d++) begin
            a_v[d] = '0;
            b_v[d] = '0;
        end

        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
        vecs[2] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0};
        vecs[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
        vecs[5] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
        vecs[6] = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
        vecs[7] = '{16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[8] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[9] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", 64'(ov[0]), 64'd0);
        check("reset S/co/ovf", 64'(dut_res(0)), 64'd0);
        check("reset in_ready", 64'(ir[0]), 64'd1);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            single_op(0, {16'd0, vecs[i].a}, {16'd0, vecs[i].b}, vecs[i].ci, vecs[i].sub,
                      {vecs[i].ovf, vecs[i].co, 16'd0, vecs[i].s}, $sformatf("w16 vec%0d", i));

        run_stream(0, 8, 0, "w16 burst");
        run_stream(0, 8, 1, "w16 stall");

        // Reset with three ops in flight.
        orr[0] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_v[0] = 32'(i + 1); b_v[0] = 32'h10; iv[0] = 1'b1;
            @(posedge clk); #1;
        end
        iv[0] = 1'b0;
        rst   = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst out_valid", 64'(ov[0]), 64'd0);
        check("midrst in_ready", 64'(ir[0]), 64'd1);
        check("midrst S/co/ovf", 64'(dut_res(0)), 64'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ov[0]) seen++;
        end
        check("midrst no ghost results", 64'(seen), 64'd0);
        single_op(0, 32'h1111, 32'h2222, 1'b0, 1'b0, {2'b00, 32'h0000_3333}, "post-reset op");

        for (int d = 1; d < 3; d++) begin
            m = (wid(d) == 32) ? 32'hFFFF_FFFF : ((32'd1 << wid(d)) - 32'd1);
            single_op(d, m, 32'd1, 1'b0, 1'b0, model(wid(d), m, 32'd1, 1'b0, 1'b0),
                      $sformatf("w%0d allones+1", wid(d)));
            single_op(d, 32'd5, 32'd7, 1'b0, 1'b1, model(wid(d), 32'd5, 32'd7, 1'b0, 1'b1),
                      $sformatf("w%0d 5-7", wid(d)));
            single_op(d, 32'd7, 32'd5, 1'b0, 1'b1, model(wid(d), 32'd7, 32'd5, 1'b0, 1'b1),
                      $sformatf("w%0d 7-5", wid(d)));
            single_op(d, m >> 1, 32'd1, 1'b0, 1'b0, model(wid(d), m >> 1, 32'd1, 1'b0, 1'b0),
                      $sformatf("w%0d maxpos+1", wid(d)));
            single_op(d, (m >> 1) + 32'd1, 32'd1, 1'b0, 1'b1,
                      model(wid(d), (m >> 1) + 32'd1, 32'd1, 1'b0, 1'b1),
                      $sformatf("w%0d minneg-1", wid(d)));
            run_stream(d, 8, 0, $sformatf("w%0d burst", wid(d)));
            run_stream(d, 8, 1, $sformatf("w%0d stall", wid(d)));
            run_stream(d, 1000, 2, $sformatf("w%0d random", wid(d)));
        end

        run_stream(0, 200, 2, "w16 random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
